// File: rtl/sprite_draw.sv
// Per-scanline sprite reader: turns the latched sprite position/flags into a
// ROM address stream and draw strobe aligned with the display beam.
module sprite_draw #(
  parameter  int SPR_WIDTH   = 19,
  parameter  int SPR_HEIGHT  = 27,
  parameter  int SPR_FRAMES  = 3,
  parameter  int SPR_SCALE_X = 2,
  parameter  int SPR_SCALE_Y = 2,
  parameter  int ANIM_DIV    = 8,
  parameter  int CORDW       = 16,
  localparam int SPR_ADDRW   = $clog2(SPR_WIDTH*SPR_HEIGHT*SPR_FRAMES)
) (
  input  logic                    i_clk_pix,
  input  logic                    i_rst_n,
  input  logic                    i_frame,
  input  logic                    i_line,
  input  logic signed [CORDW-1:0] i_sx,
  input  logic signed [CORDW-1:0] i_sy,
  input  logic signed [CORDW-1:0] i_sprx,
  input  logic signed [CORDW-1:0] i_spry,
  input  logic                    i_face_left,
  input  logic                    i_walking,
  input  logic                    i_jumping,
  output logic [SPR_ADDRW-1:0]    o_rom_addr,
  output logic                    o_drawing
);

  localparam int COLW  = (SPR_WIDTH > 1) ? $clog2(SPR_WIDTH) : 1;
  localparam int ROWW  = (SPR_HEIGHT > 1) ? $clog2(SPR_HEIGHT) : 1;
  localparam int SUBW  = (SPR_SCALE_X > 1) ? $clog2(SPR_SCALE_X) : 1;
  localparam int FSELW = (SPR_FRAMES > 1) ? $clog2(SPR_FRAMES) : 1;
  localparam int ANIMW = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;
  localparam int YSH   = $clog2(SPR_SCALE_Y);
  localparam logic signed [CORDW:0] DY_MAX = (CORDW+1)'(SPR_HEIGHT*SPR_SCALE_Y);

  typedef enum logic [1:0] {IDLE, LINE_CHK, WAIT_POS, DRAW} state_t;

  state_t                  state;
  logic signed [CORDW-1:0] sprx, spry;
  logic                    face_left;
  logic [FSELW-1:0]        frame_sel;
  logic [ANIMW-1:0]        anim_cnt;
  logic                    walk_phase;
  logic signed [CORDW:0]   dy;
  logic [SPR_ADDRW-1:0]    line_base;
  logic [COLW-1:0]         col;
  logic [SUBW-1:0]         sub_x;

  logic [FSELW-1:0]        sel_next;
  logic signed [CORDW-1:0] spry_cur;
  logic [ROWW-1:0]         row_c;
  logic [SPR_ADDRW-1:0]    line_base_c;
  logic [COLW-1:0]         col_next, c_start, c_next;
  logic                    sx_hit, dy_ok;

  // spry_cur lets a line pulse coinciding with a frame pulse use the new position
  always_comb begin
    sel_next    = i_jumping ? FSELW'(2) : ((i_walking && walk_phase) ? FSELW'(1) : FSELW'(0));
    spry_cur    = i_frame ? i_spry : spry;
    dy_ok       = (dy >= 0) && (dy < DY_MAX);
    row_c       = ROWW'(dy >>> YSH);
    line_base_c = SPR_ADDRW'(frame_sel) * SPR_ADDRW'(SPR_WIDTH*SPR_HEIGHT)
                + SPR_ADDRW'(row_c) * SPR_ADDRW'(SPR_WIDTH);
    col_next    = col + COLW'(1);
    c_start     = face_left ? COLW'(SPR_WIDTH-1) : '0;
    c_next      = face_left ? COLW'(SPR_WIDTH-1) - col_next : col_next;
    sx_hit      = ({i_sx[CORDW-1], i_sx} == ({sprx[CORDW-1], sprx} - (CORDW+1)'(2)));
  end

  // Per-frame latch of sprite state and the walk animation divider
  always_ff @(posedge i_clk_pix) begin
    if (!i_rst_n) begin
      sprx       <= '0;
      spry       <= '0;
      face_left  <= 1'b0;
      frame_sel  <= '0;
      anim_cnt   <= '0;
      walk_phase <= 1'b0;
    end else if (i_frame) begin
      sprx      <= i_sprx;
      spry      <= i_spry;
      face_left <= i_face_left;
      frame_sel <= sel_next;
      if (!i_walking) begin
        anim_cnt   <= '0;
        walk_phase <= 1'b0;
      end else if (anim_cnt == ANIMW'(ANIM_DIV-1)) begin
        anim_cnt   <= '0;
        walk_phase <= ~walk_phase;
      end else begin
        anim_cnt <= anim_cnt + ANIMW'(1);
      end
    end
  end

  // Line FSM; DRAW is entered one cycle early so ROM data lands on i_sx == sprx
  always_ff @(posedge i_clk_pix) begin
    if (!i_rst_n) begin
      state      <= IDLE;
      o_drawing  <= 1'b0;
      o_rom_addr <= '0;
      dy         <= '0;
      line_base  <= '0;
      col        <= '0;
      sub_x      <= '0;
    end else if (i_line) begin
      state     <= LINE_CHK;
      o_drawing <= 1'b0;
      dy        <= {i_sy[CORDW-1], i_sy} - {spry_cur[CORDW-1], spry_cur};
    end else begin
      case (state)
        IDLE: ;
        LINE_CHK: begin
          if (dy_ok) begin
            line_base <= line_base_c;
            state     <= WAIT_POS;
          end else begin
            state <= IDLE;
          end
        end
        WAIT_POS: begin
          if (sx_hit) begin
            state      <= DRAW;
            col        <= '0;
            sub_x      <= '0;
            o_drawing  <= 1'b1;
            o_rom_addr <= line_base + SPR_ADDRW'(c_start);
          end
        end
        DRAW: begin
          if (sub_x == SUBW'(SPR_SCALE_X-1)) begin
            if (col == COLW'(SPR_WIDTH-1)) begin
              o_drawing <= 1'b0;
              state     <= IDLE;
            end else begin
              col        <= col_next;
              sub_x      <= '0;
              o_rom_addr <= line_base + SPR_ADDRW'(c_next);
            end
          end else begin
            sub_x <= sub_x + SUBW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sprite_draw.sv
// Directed bench for sprite_draw: sweeps the beam across scanlines and checks
// the draw strobe and ROM address against hand-computed sprite geometry.
module tb_sprite_draw;

  logic               i_clk_pix = 1'b0;
  logic               i_rst_n = 1'b0;
  logic               i_frame = 1'b0;
  logic               i_line = 1'b0;
  logic signed [15:0] i_sx = '0;
  logic signed [15:0] i_sy = '0;
  logic signed [15:0] i_sprx = '0;
  logic signed [15:0] i_spry = '0;
  logic               i_face_left = 1'b0;
  logic               i_walking = 1'b0;
  logic               i_jumping = 1'b0;
  logic [10:0]        o_rom_addr;
  logic               o_drawing;

  int checks = 0;
  int passes = 0;
  int fails = 0;

  sprite_draw dut (
    .i_clk_pix  (i_clk_pix),
    .i_rst_n    (i_rst_n),
    .i_frame    (i_frame),
    .i_line     (i_line),
    .i_sx       (i_sx),
    .i_sy       (i_sy),
    .i_sprx     (i_sprx),
    .i_spry     (i_spry),
    .i_face_left(i_face_left),
    .i_walking  (i_walking),
    .i_jumping  (i_jumping),
    .o_rom_addr (o_rom_addr),
    .o_drawing  (o_drawing)
  );

  always #5 i_clk_pix = ~i_clk_pix;

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) passes++;
    else begin
      fails++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  // One-cycle frame pulse carrying the sprite state for the coming frame
  task automatic apply_stimulus(input int sprx, input int spry, input bit face, input bit walk, input bit jump);
    @(posedge i_clk_pix); #1;
    i_sprx      = 16'(sprx);
    i_spry      = 16'(spry);
    i_face_left = face;
    i_walking   = walk;
    i_jumping   = jump;
    i_sx        = -16'sd20;
    i_frame     = 1'b1;
    @(posedge i_clk_pix); #1;
    i_frame = 1'b0;
  endtask

  // Line pulse then beam sweep; run expected for 38 cycles from sx = x-1
  task automatic run_line(input int sy, input int x, input bit exp_draw, input int base,
                          input bit mirror, input int stop_k, input string tag);
    int  k;
    bit  exp_on;
    @(posedge i_clk_pix); #1;
    i_line = 1'b1;
    i_sy   = 16'(sy);
    i_sx   = -16'sd20;
    for (int s = -19; s <= x + 50; s++) begin
      @(posedge i_clk_pix); #1;
      i_line = 1'b0;
      i_sx   = 16'(s);
      @(negedge i_clk_pix);
      k      = s - (x - 1);
      exp_on = exp_draw && (k >= 0) && (k < 38);
      check_output({tag, "_drawing"}, 32'(o_drawing), 32'(exp_on));
      if (exp_on)
        check_output({tag, "_addr"}, 32'(o_rom_addr), 32'(mirror ? base + 18 - k/2 : base + k/2));
      if (stop_k >= 0 && k == stop_k) break;
    end
  endtask

  initial begin
    repeat (3) @(posedge i_clk_pix);
    @(negedge i_clk_pix);
    check_output("reset_drawing", 32'(o_drawing), 32'd0);
    check_output("reset_addr", 32'(o_rom_addr), 32'd0);
    @(posedge i_clk_pix); #1;
    i_rst_n = 1'b1;

    apply_stimulus(100, 200, 1'b0, 1'b0, 1'b0);
    run_line(200, 100, 1'b1, 0, 1'b0, -1, "right_row0");

    // position input moves without a frame pulse; the latched copy must hold
    i_sprx = 16'sd50;
    run_line(200, 100, 1'b1, 0, 1'b0, -1, "latch_hold");

    apply_stimulus(100, 200, 1'b1, 1'b0, 1'b0);
    run_line(203, 100, 1'b1, 19, 1'b1, -1, "left_row1");
    run_line(199, 100, 1'b0, 0, 1'b0, -1, "above_top");

    apply_stimulus(100, 200, 1'b0, 1'b0, 1'b1);
    run_line(253, 100, 1'b1, 1520, 1'b0, -1, "jump_row26");
    run_line(254, 100, 1'b0, 0, 1'b0, -1, "below_bottom");

    for (int f = 1; f <= 16; f++) begin
      apply_stimulus(100, 200, 1'b0, 1'b1, 1'b0);
      run_line(200, 100, 1'b1, (f >= 9) ? 513 : 0, 1'b0, 0, $sformatf("walk_f%0d", f));
    end
    apply_stimulus(100, 200, 1'b0, 1'b0, 1'b0);
    run_line(200, 100, 1'b1, 0, 1'b0, 0, "walk_drop");

    // abort at col 5 (k=10): strobe still high in the pulse cycle, low the next
    run_line(200, 100, 1'b1, 0, 1'b0, 10, "pre_abort");
    @(posedge i_clk_pix); #1;
    i_line = 1'b1;
    i_sx   = 16'sd110;
    @(negedge i_clk_pix);
    check_output("abort_pulse_drawing", 32'(o_drawing), 32'd1);
    check_output("abort_pulse_addr", 32'(o_rom_addr), 32'd5);
    @(posedge i_clk_pix); #1;
    i_line = 1'b0;
    i_sx   = 16'sd111;
    @(negedge i_clk_pix);
    check_output("abort_fall", 32'(o_drawing), 32'd0);
    run_line(200, 100, 1'b1, 0, 1'b0, -1, "after_abort");

    run_line(200, 100, 1'b1, 0, 1'b0, 5, "pre_reset");
    @(posedge i_clk_pix); #1;
    i_rst_n = 1'b0;
    i_sx    = 16'sd105;
    @(posedge i_clk_pix); #1;
    i_sx = 16'sd106;
    @(negedge i_clk_pix);
    check_output("midreset_drawing", 32'(o_drawing), 32'd0);
    check_output("midreset_addr", 32'(o_rom_addr), 32'd0);
    @(posedge i_clk_pix); #1;
    i_rst_n = 1'b1;
    for (int s = 107; s < 140; s++) begin
      @(posedge i_clk_pix); #1;
      i_sx = 16'(s);
      @(negedge i_clk_pix);
      check_output("post_reset_idle", 32'(o_drawing), 32'd0);
    end

    $display("[TB] %0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
